// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg
// Shared types and constants for the MIPS fetch stage and main control.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  // Datapath field widths
  localparam int WORD_W = 32;
  localparam int IMM_W  = 16;
  localparam int JIDX_W = 26;

  // Opcodes decoded by main control from IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2
  } fetch_state_e;

  // Word-aligned, sign-extended branch displacement
  function automatic logic [WORD_W-1:0] branch_offset(input logic [IMM_W-1:0] imm);
    return {{(WORD_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_next_pc.sv
// ============================================================================
// mips_next_pc
// Combinational next-PC selection: jump, taken beq, or sequential.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_next_pc
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] pc_i,
  input  logic [JIDX_W-1:0] jidx_i,     // IR[25:0]; IR[15:0] is the beq immediate
  input  logic              J_i,
  input  logic              B_i,
  input  logic              Zero_i,
  output logic [WORD_W-1:0] pc_plus4_o,
  output logic [WORD_W-1:0] next_pc_o
);

  logic [WORD_W-1:0] w_br_target;
  logic [WORD_W-1:0] w_j_target;

  // Sequential address and both candidate targets; all sums wrap mod 2^32
  always_comb begin
    pc_plus4_o  = pc_i + 32'd4;
    w_br_target = pc_plus4_o + branch_offset(jidx_i[IMM_W-1:0]);
    w_j_target  = {pc_plus4_o[WORD_W-1:WORD_W-4], jidx_i, 2'b00};
  end

  // Jump outranks branch; branch needs Zero to be taken
  always_comb begin
    next_pc_o = pc_plus4_o;
    if (J_i) begin
      next_pc_o = w_j_target;
    end else if (B_i && Zero_i) begin
      next_pc_o = w_br_target;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mips_fetch_unit.sv
// ============================================================================
// mips_fetch_unit
// Instruction fetch stage: PC, imem req/ready handshake, IR, next-PC commit,
// and a sticky timeout flag for a memory that never answers.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        J,
  input  logic        B,
  input  logic        Zero,
  input  logic        exec_done,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_err
);

  // TIMEOUT is at most 255, so 8 bits always hold TIMEOUT-1
  localparam int         CNT_W    = 8;
  localparam logic [7:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  // Low address bits are forced to zero so the PC can never be misaligned
  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  fetch_state_e      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       next_pc;

  mips_next_pc u_next_pc (
    .pc_i       (pc_q),
    .jidx_i     (ir_q[JIDX_W-1:0]),
    .J_i        (J),
    .B_i        (B),
    .Zero_i     (Zero),
    .pc_plus4_o (pc_plus4),
    .next_pc_o  (next_pc)
  );

  // State and datapath registers; reset abandons any fetch in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= PC_INIT;
      ir_q    <= 32'h0000_0000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sequencer: IDLE -> REQ (wait for ready, count toward timeout) -> EXEC (wait retire)
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    valid_d  = valid_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    imem_req = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_d    = imem_rdata;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = EXEC;
        end else if (cnt_q == CNT_LAST) begin
          // Request is held, not retried; counter parks at its limit
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      EXEC: begin
        if (exec_done) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = ir_q;
  assign instr_valid = valid_q;
  assign imem_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_fetch_unit.sv
// ============================================================================
// tb_mips_fetch_unit
// Directed self-checking bench. Two instances share all inputs and therefore
// step in lockstep; the second one starts at a high reset PC so jumps that
// keep the upper PC nibble can be observed.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        J = 1'b0, B = 1'b0, Zero = 1'b0, exec_done = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;

  logic        req_a, valid_a, err_a;
  logic [31:0] addr_a, instr_a, pc_a, pc4_a;
  logic        req_b, valid_b, err_b;
  logic [31:0] addr_b, instr_b, pc_b, pc4_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) u_dut_a (
    .clk(clk), .rst(rst), .J(J), .B(B), .Zero(Zero), .exec_done(exec_done),
    .imem_req(req_a), .imem_addr(addr_a), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .instr(instr_a), .instr_valid(valid_a),
    .pc(pc_a), .pc_plus4(pc4_a), .imem_err(err_a)
  );

  mips_fetch_unit #(.RESET_PC(32'h8000_0010), .TIMEOUT(16)) u_dut_b (
    .clk(clk), .rst(rst), .J(J), .B(B), .Zero(Zero), .exec_done(exec_done),
    .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .instr(instr_b), .instr_valid(valid_b),
    .pc(pc_b), .pc_plus4(pc4_b), .imem_err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Wait (bounded) for a request, let it stall `delay` cycles, then answer it
  task automatic fetch(input logic [31:0] word, input int delay);
    int n = 0;
    while (req_a !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, req_a}, 32'd1);
    repeat (delay) @(negedge clk);
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
  endtask

  // Retire the current instruction with the given control outcome
  task automatic retire(input logic j, input logic b, input logic z);
    J = j; B = b; Zero = z; exec_done = 1'b1;
    @(negedge clk);
    J = 1'b0; B = 1'b0; Zero = 1'b0; exec_done = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_pc",    pc_a, 32'h0);
    chk("rst_instr", instr_a, 32'h0);
    chk("rst_valid", {31'd0, valid_a}, 32'd0);
    chk("rst_req",   {31'd0, req_a}, 32'd0);
    chk("rst_err",   {31'd0, err_a}, 32'd0);
    chk("rst_pc_b",  pc_b, 32'h8000_0010);

    // IDLE for one cycle, then request at RESET_PC
    rst = 1'b0;
    @(negedge clk);
    chk("first_req",  {31'd0, req_a}, 32'd1);
    chk("first_addr", addr_a, 32'h0);

    // R-type fetch with ready three cycles after request
    fetch(32'h0000_0020, 3);
    chk("f1_instr", instr_a, 32'h0000_0020);
    chk("f1_valid", {31'd0, valid_a}, 32'd1);
    chk("f1_req",   {31'd0, req_a}, 32'd0);
    chk("f1_pc4",   pc4_a, 32'h4);
    retire(1'b0, 1'b0, 1'b0);
    chk("seq_pc",    pc_a, 32'h4);
    chk("seq_valid", {31'd0, valid_a}, 32'd0);
    chk("seq_req",   {31'd0, req_a}, 32'd1);
    chk("seq_pc_b",  pc_b, 32'h8000_0014);

    // Jump with B and Zero also high: jump wins
    fetch(32'h0800_0040, 0);
    retire(1'b1, 1'b1, 1'b1);
    chk("jmp_pc",   pc_a, 32'h0000_0100);
    chk("jmp_pc_b", pc_b, 32'h8000_0100);

    // beq imm=-1 taken: lands on itself
    fetch(32'h1000_FFFF, 1);
    retire(1'b0, 1'b1, 1'b1);
    chk("beq_taken", pc_a, 32'h0000_0100);

    // Same beq, Zero=0: falls through
    fetch(32'h1000_FFFF, 0);
    retire(1'b0, 1'b1, 1'b0);
    chk("beq_not_taken", pc_a, 32'h0000_0104);

    // Backward branch that wraps below zero: 0x108 - 0x10C
    fetch(32'h1000_FFBD, 0);
    retire(1'b0, 1'b1, 1'b1);
    chk("beq_wrap_pc",  pc_a, 32'hFFFF_FFFC);
    chk("beq_wrap_pc4", pc4_a, 32'h0000_0000);

    // Sequential wrap past the top of the address space
    fetch(32'h0000_0020, 0);
    retire(1'b0, 1'b0, 1'b0);
    chk("wrap_pc",  pc_a, 32'h0000_0000);
    chk("wrap_pc4", pc4_a, 32'h0000_0004);

    // Timeout: no ready; flag rises at the end of the 16th REQ cycle
    repeat (15) @(negedge clk);
    chk("to_err_before", {31'd0, err_a}, 32'd0);
    @(negedge clk);
    chk("to_err_rise", {31'd0, err_a}, 32'd1);
    chk("to_req_held", {31'd0, req_a}, 32'd1);
    repeat (5) @(negedge clk);
    chk("to_err_sticky", {31'd0, err_a}, 32'd1);
    chk("to_req_still",  {31'd0, req_a}, 32'd1);
    chk("to_addr",       addr_a, 32'h0);
    // Late ready still completes the fetch
    imem_ready = 1'b1;
    imem_rdata = 32'h8C00_0004;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    chk("late_instr", instr_a, 32'h8C00_0004);
    chk("late_valid", {31'd0, valid_a}, 32'd1);
    chk("late_err",   {31'd0, err_a}, 32'd1);

    // Reset mid-fetch with ready arriving in the same cycle
    retire(1'b0, 1'b0, 1'b0);
    chk("pre_rst_pc", pc_a, 32'h4);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #2 rst = 1'b1;
    #1;
    chk("arst_req",   {31'd0, req_a}, 32'd0);
    chk("arst_pc",    pc_a, 32'h0);
    chk("arst_instr", instr_a, 32'h0);
    chk("arst_valid", {31'd0, valid_a}, 32'd0);
    chk("arst_err",   {31'd0, err_a}, 32'd0);
    @(negedge clk);
    chk("arst_hold_instr", instr_a, 32'h0);
    // Release with ready still high: IDLE must ignore it
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ign_instr", instr_a, 32'h0);
    chk("idle_ign_valid", {31'd0, valid_a}, 32'd0);
    chk("restart_req",    {31'd0, req_a}, 32'd1);
    chk("restart_addr",   addr_a, 32'h0);
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
